cmd_issue_queue: RTL and testbench

CMD_ISSUE_QUEUE -- requirements
Module: cmd_issue_queue

---
 rtl/cmd_issue_queue.sv | 163 ++++++++++++++++
 tb/tb_cmd_issue_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_issue_queue.sv
// Command issue queue: buffers host commands in a circular FIFO and issues them one at a time
// to the data/control router, inserting a zeroed DRAIN cycle between consecutive commands.
module cmd_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_valid,
    input  logic [31:0] host_instruction,
    input  logic [31:0] host_offset,
    input  logic [31:0] host_filesize,
    output logic        host_ready,
    input  logic        acc_done,
    output logic [31:0] instruction,
    output logic [31:0] offset,
    output logic [31:0] filesize,
    output logic        busy,
    output logic        cmd_done,
    output logic        err_zero_size,
    output logic [4:0]  queue_count
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] offset;
        logic [31:0] filesize;
    } cmd_t;

    cmd_t             mem_q [DEPTH];
    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [4:0]       count_q, count_d;
    cmd_t             out_q, out_d;
    logic             busy_q, busy_d;
    logic             cmd_done_q, cmd_done_d;
    logic             err_q, err_d;
    logic             acc_prev_q, acc_prev_d;

    logic accept;
    logic push;
    logic pop;
    logic launch;
    logic done_edge;

    // Ready is decoded from the registered count so a pop on the same edge cannot raise it.
    assign host_ready = (count_q < DEPTH_C);
    assign accept     = host_valid & host_ready;
    assign push       = accept & (|host_filesize);

    // A held completion only counts once: the router must drop acc_done before completing again.
    assign done_edge  = acc_done & ~acc_prev_q;
    assign pop        = (state_q == RUN) & done_edge;
    assign launch     = (state_q == IDLE) & (count_q != 5'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (launch) state_d = RUN;
            RUN:     if (pop)    state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered router-facing outputs
    always_comb begin
        out_d      = out_q;
        busy_d     = busy_q;
        cmd_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    out_d  = mem_q[head_q];
                    busy_d = 1'b1;
                end
            end
            RUN: begin
                if (pop) begin
                    out_d      = '0;
                    busy_d     = 1'b0;
                    cmd_done_d = 1'b1;
                end
            end
            default: begin
                out_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Queue pointers, occupancy and status pulses
    always_comb begin
        head_d     = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d     = push ? tail_q + PTR_W'(1) : tail_q;
        err_d      = accept & ~(|host_filesize);
        acc_prev_d = acc_done;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            cmd_done_q <= 1'b0;
            err_q      <= 1'b0;
            acc_prev_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            cmd_done_q <= cmd_done_d;
            err_q      <= err_d;
            acc_prev_q <= acc_prev_d;
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{instr: host_instruction, offset: host_offset, filesize: host_filesize};
        end
    end

    assign instruction   = out_q.instr;
    assign offset        = out_q.offset;
    assign filesize      = out_q.filesize;
    assign busy          = busy_q;
    assign cmd_done      = cmd_done_q;
    assign err_zero_size = err_q;
    assign queue_count   = count_q;

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Directed bench for cmd_issue_queue: expected commands are queued on accept and
// compared in order whenever the queue issues a command to the router.
module tb_cmd_issue_queue;

    typedef struct {
        logic [31:0] i;
        logic [31:0] o;
        logic [31:0] f;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        host_valid = 1'b0;
    logic [31:0] host_instruction = '0;
    logic [31:0] host_offset = '0;
    logic [31:0] host_filesize = '0;
    logic        host_ready;
    logic        acc_done = 1'b0;
    logic [31:0] instruction;
    logic [31:0] offset;
    logic [31:0] filesize;
    logic        busy;
    logic        cmd_done;
    logic        err_zero_size;
    logic [4:0]  queue_count;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    cmd_issue_queue #(.DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .host_valid       (host_valid),
        .host_instruction (host_instruction),
        .host_offset      (host_offset),
        .host_filesize    (host_filesize),
        .host_ready       (host_ready),
        .acc_done         (acc_done),
        .instruction      (instruction),
        .offset           (offset),
        .filesize         (filesize),
        .busy             (busy),
        .cmd_done         (cmd_done),
        .err_zero_size    (err_zero_size),
        .queue_count      (queue_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] i, input logic [31:0] o, input logic [31:0] f);
        int n = 0;
        host_valid       = 1'b1;
        host_instruction = i;
        host_offset      = o;
        host_filesize    = f;
        while (!host_ready && n < 50) begin
            step();
            n++;
        end
        check("push_ready", 32'(host_ready), 32'd1);
        step();
        host_valid = 1'b0;
        if (f != 0) sb.push_back('{i, o, f});
    endtask

    task automatic check_head();
        exp_t e;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("head_instr", instruction, e.i);
            check("head_offset", offset, e.o);
            check("head_filesize", filesize, e.f);
        end
    endtask

    task automatic expect_issue();
        int n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        check("issue_busy", 32'(busy), 32'd1);
        check_head();
    endtask

    task automatic complete();
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        check("done_busy0", 32'(busy), 32'd0);
        check("done_instr0", instruction, 32'd0);
        check("done_offset0", offset, 32'd0);
        check("done_filesize0", filesize, 32'd0);
        check("done_pulse", 32'(cmd_done), 32'd1);
        step();
        check("done_pulse_end", 32'(cmd_done), 32'd0);
        check("gap_instr0", instruction, 32'd0);
    endtask

    initial begin
        int exp_cnt;
        int idx;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(host_ready), 32'd1);
        check("rst_count", 32'(queue_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_done", 32'(cmd_done), 32'd0);
        check("rst_err", 32'(err_zero_size), 32'd0);
        reset = 1'b1;
        step();

        // Single command with two-cycle issue latency
        push_one(32'h1, 32'h100, 32'h40);
        check("lat_count", 32'(queue_count), 32'd1);
        check("lat_busy0", 32'(busy), 32'd0);
        check("lat_instr0", instruction, 32'd0);
        step();
        check("lat_busy1", 32'(busy), 32'd1);
        check_head();
        repeat (2) step();
        check("hold_instr", instruction, 32'h1);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_count", 32'(queue_count), 32'd1);
        complete();
        check("single_count", 32'(queue_count), 32'd0);

        // Zero-size command is acknowledged but dropped
        push_one(32'h2, 32'h0, 32'h0);
        check("zero_err", 32'(err_zero_size), 32'd1);
        check("zero_count", 32'(queue_count), 32'd0);
        step();
        check("zero_err_end", 32'(err_zero_size), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_count2", 32'(queue_count), 32'd0);

        // Full queue: four accepted back-to-back, fifth held off
        for (int k = 0; k < 4; k++) push_one(32'h10 + 32'(k), 32'h200 + 32'(k), 32'h80 + 32'(k));
        check("full_count", 32'(queue_count), 32'd4);
        check("full_ready", 32'(host_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        check_head();
        host_valid       = 1'b1;
        host_instruction = 32'h14;
        host_offset      = 32'h204;
        host_filesize    = 32'h84;
        repeat (2) step();
        check("held_count", 32'(queue_count), 32'd4);
        check("held_ready", 32'(host_ready), 32'd0);

        // Pop while full: the held push waits one cycle, then lands
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        check("pwp_count", 32'(queue_count), 32'd3);
        check("pwp_done", 32'(cmd_done), 32'd1);
        check("pwp_ready", 32'(host_ready), 32'd1);
        step();
        host_valid = 1'b0;
        sb.push_back('{32'h14, 32'h204, 32'h84});
        check("pwp_count4", 32'(queue_count), 32'd4);
        check("pwp_ready0", 32'(host_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            expect_issue();
            complete();
        end
        check("drain_count", 32'(queue_count), 32'd0);

        // Wrap and ordering: ten commands, with simultaneous push and pop while occupancy holds
        for (int k = 0; k < 3; k++) push_one(32'h100 + 32'(k), 32'h1000 + 32'(k), 32'h10 + 32'(k));
        exp_cnt = 3;
        idx     = 3;
        for (int n = 0; n < 10; n++) begin
            expect_issue();
            if (idx < 10) begin
                host_valid       = 1'b1;
                host_instruction = 32'h100 + 32'(idx);
                host_offset      = 32'h1000 + 32'(idx);
                host_filesize    = 32'h10 + 32'(idx);
                acc_done         = 1'b1;
                check("swap_ready", 32'(host_ready), 32'd1);
                step();
                host_valid = 1'b0;
                acc_done   = 1'b0;
                sb.push_back('{32'h100 + 32'(idx), 32'h1000 + 32'(idx), 32'h10 + 32'(idx)});
                idx++;
                check("swap_count", 32'(queue_count), 32'(exp_cnt));
                check("swap_done", 32'(cmd_done), 32'd1);
                check("swap_instr0", instruction, 32'd0);
                step();
                check("swap_gap", instruction, 32'd0);
            end else begin
                complete();
                exp_cnt--;
                check("wrap_count", 32'(queue_count), 32'(exp_cnt));
            end
        end

        // Held acc_done counts as a single completion
        push_one(32'h50, 32'h500, 32'h5);
        push_one(32'h51, 32'h510, 32'h6);
        expect_issue();
        acc_done = 1'b1;
        step();
        check("hold_ack_done", 32'(cmd_done), 32'd1);
        check("hold_ack_count", 32'(queue_count), 32'd1);
        step();
        check("hold_ack_done0", 32'(cmd_done), 32'd0);
        step();
        check("hold_ack_busy", 32'(busy), 32'd1);
        check_head();
        step();
        check("hold_ack_busy2", 32'(busy), 32'd1);
        check("hold_ack_count2", 32'(queue_count), 32'd1);
        check("hold_ack_done1", 32'(cmd_done), 32'd0);
        acc_done = 1'b0;
        step();
        check("hold_ack_busy3", 32'(busy), 32'd1);
        complete();
        check("hold_ack_empty", 32'(queue_count), 32'd0);

        // Reset mid-RUN discards everything without a completion
        for (int k = 0; k < 3; k++) push_one(32'h70 + 32'(k), 32'h700, 32'h7);
        expect_issue();
        #2;
        reset = 1'b0;
        #1;
        check("mrst_instr", instruction, 32'd0);
        check("mrst_offset", offset, 32'd0);
        check("mrst_filesize", filesize, 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_count", 32'(queue_count), 32'd0);
        check("mrst_done", 32'(cmd_done), 32'd0);
        check("mrst_ready", 32'(host_ready), 32'd1);
        sb.delete();
        step();
        check("mrst_done2", 32'(cmd_done), 32'd0);
        reset = 1'b1;
        step();
        check("post_rst_done", 32'(cmd_done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_count", 32'(queue_count), 32'd0);
        push_one(32'h99, 32'h900, 32'h9);
        expect_issue();
        complete();
        check("post_rst_empty", 32'(queue_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
